unidade_controle: RTL and testbench
===================================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have parameter CICLOS_ESPERA, default 15, giving the maximum BUSCA/IMED wait cycles before a bus timeout.
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, with synchronous, active-high reset.
REQ-004 The block SHALL have port Instrucao, input, 8, the memory data byte: opcode [7:5], rd [4:3], rs [2:1].
REQ-005 The block SHALL have port MemPronta, input, 1, the memory handshake: data valid this cycle.
REQ-006 The block SHALL have port Zero, input, 1, the ULA Zero flag.
REQ-007 The block SHALL have port ALUOp, output, 2, the ULA operation select.
REQ-008 The block SHALL have the following 1-bit outputs: MemLe (memory read request), IREscreve (load IR), PCEscreve (update PC), RegEscreve (write register rd), RegFonte (0 = ULA result, 1 = memory byte), Parado (halted) and ErroBarramento (timeout sticky flag).
REQ-009 The block SHALL have port PCFonte, output, 1, selecting PC+1 (0) or the memory byte as jump target (1).
REQ-010 The block SHALL have port Estado, output, 3, the current state code for debug.

Function
REQ-011 The state codes SHALL be BUSCA=000, DECOD=001, EXEC=010, ESCRITA=011, IMED=100, PARADO=101; codes 110 and 111 SHALL go to BUSCA on the next edge.
REQ-012 In BUSCA the block SHALL assert MemLe; when MemPronta=1 it SHALL assert IREscreve, PCEscreve and PCFonte=0 in that same cycle and go to DECOD.
REQ-013 While MemPronta=0 in BUSCA or IMED, the block SHALL stay in the state and increment a wait counter.
REQ-014 When the wait counter reaches CICLOS_ESPERA, the block SHALL set ErroBarramento and go to PARADO.
REQ-015 The wait counter SHALL clear on every state change.
REQ-016 DECOD SHALL take one cycle and dispatch on opcode: 000 ADD, 001 NEG, 010 SUB and 011 SLT go to EXEC; 100 LDI, 101 BEQ and 110 JMP go to IMED; 111 HLT goes to PARADO.
REQ-017 In EXEC the block SHALL drive ALUOp = opcode[1:0] (00, 01, 10, 11); for BEQ it SHALL drive ALUOp=10.
REQ-018 For ALU opcodes EXEC SHALL go to ESCRITA; for BEQ it SHALL latch Zero into an internal register ZeroReg and go to IMED.
REQ-019 ESCRITA SHALL hold ALUOp at its EXEC value, assert RegEscreve with RegFonte=0 for one cycle, then go to BUSCA.
REQ-020 IMED SHALL assert MemLe; on MemPronta=1: LDI SHALL assert RegEscreve with RegFonte=1 and PCEscreve with PCFonte=0; JMP SHALL assert PCEscreve with PCFonte=1; BEQ SHALL assert PCEscreve with PCFonte = ZeroReg. It SHALL then go to BUSCA.
REQ-021 Since BEQ reaches IMED only via EXEC, DECOD SHALL route BEQ to EXEC first, overriding REQ-016.
REQ-022 Latencies with MemPronta=1 SHALL be: ALU op 4 cycles, LDI/JMP 3 cycles, BEQ 4 cycles, counted BUSCA to the next BUSCA.
REQ-023 In PARADO, Parado=1, all strobes SHALL be 0 and the state SHALL hold until reset.
REQ-024 Outside the cases listed above, MemLe, IREscreve, PCEscreve, RegEscreve, RegFonte and PCFonte SHALL be 0, and ALUOp SHALL be 00.
REQ-025 All outputs SHALL be decoded from the registered state and IR fields only, with no combinational path from Zero to any output.
REQ-026 MemPronta arriving in any state other than BUSCA or IMED SHALL be ignored.

Reset
REQ-027 With reset=1 at a clock edge, the next state SHALL be BUSCA, with the wait counter, ZeroReg, ErroBarramento and the internal IR copy all cleared to 0.
REQ-028 Reset SHALL take priority over every transition, including a MemPronta or strobe in the same cycle.
REQ-029 Reset mid-instruction SHALL abort it with no RegEscreve or PCEscreve in the following cycle.
REQ-030 After reset, every output SHALL be 0 except MemLe=1 (BUSCA).

Verification
REQ-031 The bench SHALL check: reset, then ADD (00000010) with MemPronta=1 -> Estado 000, 001, 010, 011; ALUOp=00 in EXEC and ESCRITA; RegEscreve=1 only in ESCRITA.
REQ-032 The bench SHALL check: BEQ with Zero=1 in EXEC, then target byte 0x40 -> in IMED, PCEscreve=1 and PCFonte=1; with Zero=0, PCFonte=0.
REQ-033 The bench SHALL check: MemPronta held at 0 in BUSCA -> after 15 cycles, ErroBarramento=1, Estado=101 and Parado=1.
REQ-034 The bench SHALL check: HLT (11100000) -> PARADO with all strobes 0 for 20 cycles; reset then returns Estado=000.
REQ-035 The bench SHALL check: reset asserted during ESCRITA -> no RegEscreve on the next edge and Estado=000.
REQ-036 The bench SHALL check: LDI then JMP -> RegEscreve=1 with RegFonte=1 in IMED for LDI; PCFonte=1 for JMP; and 3 cycles per instruction.

Source files
------------

// File: rtl/unidade_controle.sv
// Multicycle control unit: fetch, decode, ALU execute/writeback and
// immediate-byte fetch for LDI/BEQ/JMP, with a bus-timeout halt.
module unidade_controle #(
  parameter int CICLOS_ESPERA = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] Instrucao,
  input  logic       MemPronta,
  input  logic       Zero,
  output logic [1:0] ALUOp,
  output logic       MemLe,
  output logic       IREscreve,
  output logic       PCEscreve,
  output logic       RegEscreve,
  output logic       RegFonte,
  output logic       Parado,
  output logic       ErroBarramento,
  output logic       PCFonte,
  output logic [2:0] Estado
);

  typedef enum logic [2:0] {
    BUSCA   = 3'b000,
    DECOD   = 3'b001,
    EXEC    = 3'b010,
    ESCRITA = 3'b011,
    IMED    = 3'b100,
    PARADO  = 3'b101
  } estado_t;

  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_BEQ = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam int CW = $clog2(CICLOS_ESPERA + 1);
  localparam logic [CW-1:0] LIMITE = CW'(CICLOS_ESPERA - 1);

  estado_t       estado, estado_nx;
  logic [CW-1:0] espera, espera_nx;
  logic [2:0]    opcode, opcode_nx;
  logic          zero_reg, zero_nx;
  logic          erro, erro_nx;

  // rd/rs belong to the datapath; only the opcode is kept here
  logic unused_campos;
  assign unused_campos = ^Instrucao[4:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= BUSCA;
      espera   <= '0;
      opcode   <= '0;
      zero_reg <= 1'b0;
      erro     <= 1'b0;
    end else begin
      estado   <= estado_nx;
      espera   <= espera_nx;
      opcode   <= opcode_nx;
      zero_reg <= zero_nx;
      erro     <= erro_nx;
    end
  end

  always_comb begin
    estado_nx  = estado;
    espera_nx  = '0;
    opcode_nx  = opcode;
    zero_nx    = zero_reg;
    erro_nx    = erro;
    ALUOp      = 2'b00;
    MemLe      = 1'b0;
    IREscreve  = 1'b0;
    PCEscreve  = 1'b0;
    RegEscreve = 1'b0;
    RegFonte   = 1'b0;
    PCFonte    = 1'b0;
    case (estado)
      BUSCA: begin
        MemLe = 1'b1;
        if (MemPronta) begin
          IREscreve = 1'b1;
          PCEscreve = 1'b1;
          opcode_nx = Instrucao[7:5];
          estado_nx = DECOD;
        end else if (espera == LIMITE) begin
          erro_nx   = 1'b1;
          estado_nx = PARADO;
        end else begin
          espera_nx = espera + 1'b1;
        end
      end
      DECOD: begin
        unique case (opcode)
          OP_HLT:         estado_nx = PARADO;
          OP_LDI, OP_JMP: estado_nx = IMED;
          default:        estado_nx = EXEC;
        endcase
      end
      EXEC: begin
        if (opcode == OP_BEQ) begin
          ALUOp     = 2'b10;
          zero_nx   = Zero;
          estado_nx = IMED;
        end else begin
          ALUOp     = opcode[1:0];
          estado_nx = ESCRITA;
        end
      end
      ESCRITA: begin
        ALUOp      = opcode[1:0];
        RegEscreve = 1'b1;
        estado_nx  = BUSCA;
      end
      IMED: begin
        MemLe = 1'b1;
        if (MemPronta) begin
          unique case (opcode)
            OP_LDI: begin
              RegEscreve = 1'b1;
              RegFonte   = 1'b1;
              PCEscreve  = 1'b1;
            end
            OP_JMP: begin
              PCEscreve = 1'b1;
              PCFonte   = 1'b1;
            end
            OP_BEQ: begin
              PCEscreve = 1'b1;
              PCFonte   = zero_reg;
            end
            default: ;
          endcase
          estado_nx = BUSCA;
        end else if (espera == LIMITE) begin
          erro_nx   = 1'b1;
          estado_nx = PARADO;
        end else begin
          espera_nx = espera + 1'b1;
        end
      end
      PARADO: estado_nx = PARADO;
      default: estado_nx = BUSCA;
    endcase
  end

  assign Parado         = (estado == PARADO);
  assign ErroBarramento = erro;
  assign Estado         = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed testbench for unidade_controle.
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] Instrucao = '0;
  logic       MemPronta = 1'b0;
  logic       Zero = 1'b0;
  logic [1:0] ALUOp;
  logic       MemLe, IREscreve, PCEscreve, RegEscreve;
  logic       RegFonte, Parado, ErroBarramento, PCFonte;
  logic [2:0] Estado;

  int errors = 0;
  int checks = 0;

  unidade_controle #(.CICLOS_ESPERA(15)) dut (
    .clock(clock), .reset(reset), .Instrucao(Instrucao),
    .MemPronta(MemPronta), .Zero(Zero), .ALUOp(ALUOp),
    .MemLe(MemLe), .IREscreve(IREscreve), .PCEscreve(PCEscreve),
    .RegEscreve(RegEscreve), .RegFonte(RegFonte), .Parado(Parado),
    .ErroBarramento(ErroBarramento), .PCFonte(PCFonte),
    .Estado(Estado)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    MemPronta = 1'b0;
    Zero = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    logic [9:0] outs;
    do_reset();
    outs = {ALUOp, IREscreve, PCEscreve, RegEscreve,
            RegFonte, PCFonte, Parado, ErroBarramento, MemLe};
    checks++;
    if (Estado !== 3'b000) begin
      errors++;
      $display("FAIL reset_estado got %b exp 000", Estado);
    end
    checks++;
    if (outs !== 10'b0000000001) begin
      errors++;
      $display("FAIL reset_outs got %b exp 0000000001", outs);
    end
  endtask

  task automatic test_alu(input logic [7:0] instr);
    logic [1:0] exp_op;
    exp_op = instr[6:5];
    do_reset();
    Instrucao = instr;
    MemPronta = 1'b1;
    #1;
    checks++;
    if ({Estado, MemLe, IREscreve, PCEscreve, PCFonte, RegEscreve}
        !== 8'b000_1110_0) begin
      errors++;
      $display("FAIL alu_busca op=%b got %b %b%b%b%b%b", instr[7:5],
               Estado, MemLe, IREscreve, PCEscreve, PCFonte, RegEscreve);
    end
    tick();
    MemPronta = 1'b0;
    #1;
    checks++;
    if ({Estado, RegEscreve, MemLe} !== 5'b001_0_0) begin
      errors++;
      $display("FAIL alu_decod got estado=%b reg=%b", Estado, RegEscreve);
    end
    tick();
    MemPronta = 1'b1;
    #1;
    checks++;
    if ({Estado, ALUOp, RegEscreve, MemLe, IREscreve}
        !== {3'b010, exp_op, 3'b000}) begin
      errors++;
      $display("FAIL alu_exec got estado=%b aluop=%b reg=%b exp aluop=%b",
               Estado, ALUOp, RegEscreve, exp_op);
    end
    tick();
    MemPronta = 1'b0;
    #1;
    checks++;
    if ({Estado, ALUOp, RegEscreve, RegFonte, PCEscreve}
        !== {3'b011, exp_op, 3'b100}) begin
      errors++;
      $display("FAIL alu_escrita got estado=%b aluop=%b reg=%b fonte=%b",
               Estado, ALUOp, RegEscreve, RegFonte);
    end
    tick();
    checks++;
    if (Estado !== 3'b000 || RegEscreve !== 1'b0) begin
      errors++;
      $display("FAIL alu_latencia got estado=%b exp 000", Estado);
    end
  endtask

  task automatic test_beq(input logic z);
    do_reset();
    Instrucao = 8'b10100000;
    MemPronta = 1'b1;
    tick();
    MemPronta = 1'b0;
    tick();
    Zero = z;
    #1;
    checks++;
    if ({Estado, ALUOp, PCEscreve} !== 6'b010_10_0) begin
      errors++;
      $display("FAIL beq_exec got estado=%b aluop=%b", Estado, ALUOp);
    end
    tick();
    Zero = ~z;
    Instrucao = 8'h40;
    #1;
    checks++;
    if ({Estado, MemLe, PCEscreve} !== 5'b100_1_0) begin
      errors++;
      $display("FAIL beq_imed_wait got estado=%b le=%b pce=%b",
               Estado, MemLe, PCEscreve);
    end
    MemPronta = 1'b1;
    #1;
    checks++;
    if ({PCEscreve, PCFonte, RegEscreve} !== {1'b1, z, 1'b0}) begin
      errors++;
      $display("FAIL beq_imed z=%b got pce=%b pcf=%b reg=%b exp pcf=%b",
               z, PCEscreve, PCFonte, RegEscreve, z);
    end
    tick();
    MemPronta = 1'b0;
    Zero = 1'b0;
    checks++;
    if (Estado !== 3'b000) begin
      errors++;
      $display("FAIL beq_latencia got estado=%b exp 000", Estado);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if ({Estado, ErroBarramento, MemLe} !== 5'b000_0_1) begin
      errors++;
      $display("FAIL timeout_early got estado=%b erro=%b",
               Estado, ErroBarramento);
    end
    tick();
    checks++;
    if ({Estado, ErroBarramento, Parado, MemLe} !== 6'b101_1_1_0) begin
      errors++;
      $display("FAIL timeout_busca got estado=%b erro=%b parado=%b",
               Estado, ErroBarramento, Parado);
    end
    MemPronta = 1'b1;
    tick();
    MemPronta = 1'b0;
    checks++;
    if ({Estado, ErroBarramento} !== 4'b101_1) begin
      errors++;
      $display("FAIL timeout_hold got estado=%b erro=%b",
               Estado, ErroBarramento);
    end
    do_reset();
    checks++;
    if (ErroBarramento !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got erro=%b exp 0", ErroBarramento);
    end
    Instrucao = 8'b10000000;
    MemPronta = 1'b1;
    tick();
    MemPronta = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if ({Estado, ErroBarramento} !== 4'b101_1) begin
      errors++;
      $display("FAIL timeout_imed got estado=%b erro=%b",
               Estado, ErroBarramento);
    end
  endtask

  task automatic test_hlt;
    int bad;
    bad = 0;
    do_reset();
    Instrucao = 8'b11100000;
    MemPronta = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      MemPronta = i[0];
      Zero = i[1];
      #1;
      if ({Estado, Parado, ErroBarramento, ALUOp, MemLe, IREscreve,
           PCEscreve, RegEscreve, RegFonte, PCFonte}
          !== {3'b101, 1'b1, 9'b0})
        bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hlt_parado got %0d bad cycles exp 0", bad);
    end
    MemPronta = 1'b0;
    do_reset();
    checks++;
    if ({Estado, Parado} !== 4'b000_0) begin
      errors++;
      $display("FAIL hlt_reset got estado=%b parado=%b", Estado, Parado);
    end
  endtask

  task automatic test_reset_escrita;
    do_reset();
    Instrucao = 8'b00000010;
    MemPronta = 1'b1;
    tick();
    MemPronta = 1'b0;
    tick();
    tick();
    checks++;
    if ({Estado, RegEscreve} !== 4'b011_1) begin
      errors++;
      $display("FAIL rst_escrita_pre got estado=%b reg=%b",
               Estado, RegEscreve);
    end
    reset = 1'b1;
    MemPronta = 1'b1;
    tick();
    reset = 1'b0;
    MemPronta = 1'b0;
    #1;
    checks++;
    if ({Estado, RegEscreve, PCEscreve} !== 5'b000_0_0) begin
      errors++;
      $display("FAIL rst_escrita got estado=%b reg=%b pce=%b",
               Estado, RegEscreve, PCEscreve);
    end
  endtask

  task automatic test_ldi_jmp;
    do_reset();
    Instrucao = 8'b10001000;
    MemPronta = 1'b1;
    tick();
    MemPronta = 1'b0;
    tick();
    Instrucao = 8'h55;
    MemPronta = 1'b1;
    #1;
    checks++;
    if ({Estado, RegEscreve, RegFonte, PCEscreve, PCFonte, MemLe}
        !== 8'b100_1_1_1_0_1) begin
      errors++;
      $display("FAIL ldi_imed got estado=%b reg=%b fonte=%b pce=%b pcf=%b",
               Estado, RegEscreve, RegFonte, PCEscreve, PCFonte);
    end
    Instrucao = 8'b11000000;
    tick();
    checks++;
    if ({Estado, IREscreve} !== 4'b000_1) begin
      errors++;
      $display("FAIL ldi_latencia got estado=%b ire=%b", Estado, IREscreve);
    end
    tick();
    MemPronta = 1'b0;
    tick();
    Instrucao = 8'h20;
    MemPronta = 1'b1;
    #1;
    checks++;
    if ({Estado, PCEscreve, PCFonte, RegEscreve} !== 6'b100_1_1_0) begin
      errors++;
      $display("FAIL jmp_imed got estado=%b pce=%b pcf=%b reg=%b",
               Estado, PCEscreve, PCFonte, RegEscreve);
    end
    tick();
    MemPronta = 1'b0;
    checks++;
    if (Estado !== 3'b000) begin
      errors++;
      $display("FAIL jmp_latencia got estado=%b exp 000", Estado);
    end
  endtask

  initial begin
    test_reset();
    test_alu(8'b00000010);
    test_alu(8'b00100000);
    test_alu(8'b01011110);
    test_alu(8'b01100001);
    test_beq(1'b1);
    test_beq(1'b0);
    test_timeout();
    test_hlt();
    test_reset_escrita();
    test_ldi_jmp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
